// File: rtl/fir_out_fifo.sv
// Output FIFO behind the FIR core: absorbs single-cycle y pulses and replays them
// as an AXI-Stream master with counted tlast, fill level, sticky overflow and frame_done.
module fir_out_fifo #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pDEPTH      = 16,
  parameter int unsigned pPTR_WIDTH  = 4,
  parameter int unsigned pLEN_WIDTH  = 10
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   in_valid,
  input  logic [pDATA_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic [pLEN_WIDTH-1:0]  data_length,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic [pPTR_WIDTH:0]    level,
  output logic                   ovf,
  input  logic                   clr_ovf,
  output logic                   frame_done
);

  localparam logic [pPTR_WIDTH-1:0] LAST_IDX   = pPTR_WIDTH'(pDEPTH - 1);
  localparam logic [pPTR_WIDTH:0]   LEVEL_FULL = (pPTR_WIDTH + 1)'(pDEPTH);
  localparam logic [pPTR_WIDTH:0]   LEVEL_ONE  = (pPTR_WIDTH + 1)'(1);
  localparam logic [pLEN_WIDTH-1:0] LEN_ONE    = pLEN_WIDTH'(1);

  // Each entry is {last, data}
  logic [pDATA_WIDTH:0]   mem_q [pDEPTH];

  logic [pPTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [pPTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [pPTR_WIDTH:0]    level_q, level_d;
  logic [pLEN_WIDTH-1:0]  in_cnt_q, in_cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   frame_done_q, frame_done_d;

  logic                   full_s;
  logic                   valid_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   drop_s;
  logic                   last_bit_s;
  logic [pDATA_WIDTH:0]   head_s;

  assign full_s  = (level_q == LEVEL_FULL);
  assign valid_s = (level_q != '0);
  assign head_s  = mem_q[rd_ptr_q];
  assign pop_s   = valid_s && m_tready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the sample
  assign push_s  = in_valid && (!full_s || pop_s);
  assign drop_s  = in_valid && full_s && !pop_s;

  assign last_bit_s = in_last ||
                      ((data_length != '0) && (in_cnt_q == (data_length - LEN_ONE)));

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    level_d      = level_q;
    in_cnt_d     = in_cnt_q;
    ovf_d        = ovf_q;
    frame_done_d = pop_s && head_s[pDATA_WIDTH];

    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      in_cnt_d = last_bit_s ? '0 : in_cnt_q + LEN_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
      in_cnt_d = in_cnt_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase

    // Setting wins over clearing when both happen together
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      in_cnt_q     <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      in_cnt_q     <= in_cnt_d;
      ovf_q        <= ovf_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage is not reset; the level gates everything read out of it
  always_ff @(posedge axis_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {last_bit_s, in_data};
    end
  end

  assign in_ready   = !full_s;
  assign m_tvalid   = valid_s;
  assign m_tdata    = valid_s ? head_s[pDATA_WIDTH-1:0] : '0;
  assign m_tlast    = valid_s && head_s[pDATA_WIDTH];
  assign level      = level_q;
  assign ovf        = ovf_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed self-checking bench for fir_out_fifo; each task drives one scenario
// and compares against hand-computed values.
module tb_fir_out_fifo;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [9:0]  data_length;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [4:0]  level;
  logic        ovf;
  logic        clr_ovf;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  fir_out_fifo dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .data_length (data_length),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tlast     (m_tlast),
    .level       (level),
    .ovf         (ovf),
    .clr_ovf     (clr_ovf),
    .frame_done  (frame_done)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic test_reset();
    axis_rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    data_length = '0; m_tready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    axis_rst = 1'b0;
    tick();
    n_checks++;
    if ({m_tvalid, m_tlast, ovf, frame_done, in_ready} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_flags got %b want 00001", {m_tvalid, m_tlast, ovf, frame_done, in_ready});
    end
    n_checks++;
    if (level !== 5'd0 || m_tdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_level_data got level=%0d data=%h want 0/0", level, m_tdata);
    end
  endtask

  task automatic test_counted_tlast();
    data_length = 10'd5; m_tready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_data = 32'(k);
      tick();
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'(k) || m_tlast !== (k == 5) || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL t1_beat%0d got v=%b d=%0d l=%b fd=%b want v=1 d=%0d l=%b fd=0",
                 k, m_tvalid, m_tdata, m_tlast, frame_done, k, (k == 5));
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (frame_done !== 1'b1 || m_tvalid !== 1'b0 || level !== 5'd0) begin
      n_fail++; $display("FAIL t1_frame_done got fd=%b v=%b lvl=%0d want 1/0/0", frame_done, m_tvalid, level);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL t1_frame_done_pulse got %b want 0", frame_done);
    end
  endtask

  task automatic test_overflow();
    data_length = 10'd0; m_tready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(k);
      tick();
    end
    n_checks++;
    if (level !== 5'd16 || in_ready !== 1'b0 || ovf !== 1'b0 || m_tdata !== 32'h100) begin
      n_fail++; $display("FAIL t2_full got lvl=%0d rdy=%b ovf=%b d=%h want 16/0/0/100", level, in_ready, ovf, m_tdata);
    end
    in_data = 32'hDEAD;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (level !== 5'd16 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL t2_overflow got lvl=%0d ovf=%b want 16/1", level, ovf);
    end
    m_tready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'h100 + 32'(k)) begin
        n_fail++; $display("FAIL t2_drain%0d got v=%b d=%h want 1/%h", k, m_tvalid, m_tdata, 32'h100 + 32'(k));
      end
      tick();
    end
    n_checks++;
    if (level !== 5'd0 || m_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL t2_empty got lvl=%0d v=%b want 0/0", level, m_tvalid);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL t2_clr_ovf got %b want 0", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    m_tready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_data = 32'h200 + 32'(k);
      tick();
    end
    in_data = 32'h55; m_tready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (level !== 5'd16 || ovf !== 1'b0 || m_tdata !== 32'h201) begin
      n_fail++; $display("FAIL t3_push_pop got lvl=%0d ovf=%b d=%h want 16/0/201", level, ovf, m_tdata);
    end
    for (int k = 1; k <= 16; k++) begin
      n_checks++;
      if (m_tdata !== ((k == 16) ? 32'h55 : 32'h200 + 32'(k))) begin
        n_fail++; $display("FAIL t3_drain%0d got %h want %h", k, m_tdata, (k == 16) ? 32'h55 : 32'h200 + 32'(k));
      end
      tick();
    end
    n_checks++;
    if (level !== 5'd0) begin
      n_fail++; $display("FAIL t3_empty got lvl=%0d want 0", level);
    end
  endtask

  task automatic test_in_last();
    data_length = 10'd0; m_tready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = 32'hA0 + 32'(k); in_last = (k == 3);
      tick();
      n_checks++;
      if (m_tdata !== 32'hA0 + 32'(k) || m_tlast !== (k == 3) || frame_done !== (k == 4)) begin
        n_fail++;
        $display("FAIL t4_beat%0d got d=%h l=%b fd=%b want d=%h l=%b fd=%b",
                 k, m_tdata, m_tlast, frame_done, 32'hA0 + 32'(k), (k == 3), (k == 4));
      end
    end
    in_last = 1'b0;
    // Beat 4 opened a new frame, so with length 2 the next sample closes it
    data_length = 10'd2; in_data = 32'hB0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (m_tdata !== 32'hB0 || m_tlast !== 1'b1) begin
      n_fail++; $display("FAIL t4_new_frame got d=%h l=%b want B0/1", m_tdata, m_tlast);
    end
    tick(); tick();
  endtask

  task automatic test_reset_midframe();
    data_length = 10'd8; m_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 32'hC0 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (level !== 5'd3 || m_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL t5_prefill got lvl=%0d v=%b want 3/1", level, m_tvalid);
    end
    axis_rst = 1'b1;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || level !== 5'd0 || m_tdata !== 32'd0) begin
      n_fail++; $display("FAIL t5_async_rst got v=%b lvl=%0d d=%h want 0/0/0", m_tvalid, level, m_tdata);
    end
    tick();
    axis_rst = 1'b0; m_tready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = 32'hD0 + 32'(k);
      tick();
      n_checks++;
      if (m_tdata !== 32'hD0 + 32'(k) || m_tlast !== (k == 8)) begin
        n_fail++; $display("FAIL t5_beat%0d got d=%h l=%b want d=%h l=%b", k, m_tdata, m_tlast, 32'hD0 + 32'(k), (k == 8));
      end
    end
    in_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_ovf_clear();
    data_length = 10'd0; m_tready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1; in_data = 32'hE00 + 32'(k);
      tick();
    end
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++; $display("FAIL t6_ovf_set got %b want 1", ovf);
    end
    clr_ovf = 1'b1;
    tick();
    n_checks++;
    if (ovf !== 1'b1 || level !== 5'd16) begin
      n_fail++; $display("FAIL t6_set_wins got ovf=%b lvl=%0d want 1/16", ovf, level);
    end
    in_valid = 1'b0;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL t6_clear got %b want 0", ovf);
    end
    m_tready = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    n_checks++;
    if (level !== 5'd0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL t6_drain got lvl=%0d ovf=%b want 0/0", level, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_counted_tlast();
    test_overflow();
    test_full_push_pop();
    test_in_last();
    test_reset_midframe();
    test_ovf_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
